hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  request present this cycle.
REQ-004 req_op  in  3  hilo_op_t: 000 NOP, 001 MULTU, 010 MULT, 011 MTHI, 100 MTLO, 101 MADDU, 110 MADD, 111 MSUB.
REQ-005 req_a, req_b  in  32 each  operands (rs, rt); MTHI/MTLO use req_a only.
REQ-006 req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-007 busy  out  1  high whenever state != IDLE.
REQ-008 flush  in  1  discard any in-flight multiply result.
REQ-009 hi, lo  out  32 each  architectural HI/LO registers, driven directly from flops.
REQ-010 mul_op  out  2  to multiplier: 01 unsigned, 10 signed, 00 idle.
REQ-011 mul_a, mul_b  out  32 each  multiplier operands.
REQ-012 mul_c  in  64  multiplier product, valid while mul_done is high after an issue.
REQ-013 mul_done  in  1  multiplier idle/result-valid flag; stays high until one edge after an issue.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT and DRAIN, held in a registered FSM.
REQ-015 IDLE, accepted MULT/MULTU/MADD/MADDU/MSUB: latch operands and op, then go to ISSUE.
REQ-016 IDLE, accepted MTHI/MTLO: write req_a to hi/lo on the same edge and stay in IDLE.
REQ-017 IDLE, accepted NOP: no effect.
REQ-018 ISSUE: drive registered mul_op (10 for MULT/MADD/MSUB, 01 otherwise), mul_a and mul_b for exactly one cycle, then go to WAIT unconditionally.
REQ-019 mul_op SHALL be 00 in every state other than ISSUE.
REQ-020 WAIT: while mul_done is low, hold.
REQ-021 WAIT, mul_done high: on that edge write {hi,lo} and return to IDLE.
  - MULT/MULTU: {hi,lo} <= mul_c.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + mul_c.
  - MSUB: {hi,lo} <= {hi,lo} - mul_c.
  - All arithmetic is modulo 2^64; carries or borrows beyond bit 63 are dropped.
REQ-022 Latency with a 4-cycle multiplier: request accepted at edge 0, ISSUE at edge 1, mul_done high after edge 5, hi/lo updated and req_ready high after edge 6.
REQ-023 flush in ISSUE: the issue still occurs, then go to DRAIN.
REQ-024 flush in WAIT with mul_done low: go to DRAIN.
REQ-025 flush in WAIT with mul_done high: no HI/LO write; go to IDLE.
REQ-026 DRAIN: wait for mul_done high, never write hi/lo, then go to IDLE.
REQ-027 flush in IDLE: the concurrent request is not accepted.
REQ-028 DRAIN precedence: flush has no further effect; a new request is not accepted until IDLE.

Reset
REQ-029 resetn low, asynchronously: state=IDLE, hi=lo=0, mul_op=00, mul_a=mul_b=0, latched operands/op=0.
REQ-030 Mid-operation reset abandons the operation; the multiplier is reset by the same resetn.

Configuration
REQ-031 Macro HILO_MADD_EN defined: ops 101/110/111 accumulate per REQ-021.
REQ-032 Macro HILO_MADD_EN undefined: ops 101/110/111 are accepted as NOP, the accumulator adder/subtractor is not built, and hi/lo are unchanged.

Structure
REQ-033 Package hilo_pkg SHALL hold hilo_op_t, the FSM state enum, and the mul_op encodings MUL_IDLE/MUL_UNSIGNED/MUL_SIGNED.
REQ-034 No sub-module; the multiplier is instantiated by the parent and connected via the mul_* ports.

Verification
REQ-035 MULT a=0xFFFFFFFE (-2), b=3 -> mul_op=10 for one cycle; after edge 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> both written with no busy cycle; req_ready stays high.
REQ-037 With HILO_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0; then MSUB 1*1 -> hi=0, lo=0xFFFFFFFF.
REQ-038 Without HILO_MADD_EN: op 110 with a=b=5 -> hi/lo unchanged and mul_op stays 00.
REQ-039 MULTU 7*6, flush two cycles after acceptance -> DRAIN until mul_done, hi/lo unchanged, next request accepted afterwards.
REQ-040 resetn low during WAIT -> immediately state IDLE, hi=lo=0, mul_op=00, req_ready=1.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and encodings for the HI/LO multiply/accumulate unit.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULTU = 3'b001,
        OP_MULT  = 3'b010,
        OP_MTHI  = 3'b011,
        OP_MTLO  = 3'b100,
        OP_MADDU = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } hilo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } hilo_state_t;

    localparam logic [1:0] MUL_IDLE     = 2'b00;
    localparam logic [1:0] MUL_UNSIGNED = 2'b01;
    localparam logic [1:0] MUL_SIGNED   = 2'b10;

    function automatic logic [1:0] mul_encoding(input hilo_op_t op);
        return (op == OP_MULT || op == OP_MADD || op == OP_MSUB) ? MUL_SIGNED : MUL_UNSIGNED;
    endfunction

    function automatic logic is_acc(input hilo_op_t op);
        return (op == OP_MADDU || op == OP_MADD || op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register unit: sequences one external multiplier and updates HI/LO.
// Define HILO_MADD_EN to build the MADDU/MADD/MSUB accumulate path.
//
// state    | meaning
// ST_IDLE  | ready for a request; MTHI/MTLO complete here
// ST_ISSUE | mul_op/mul_a/mul_b presented to the multiplier for one cycle
// ST_WAIT  | waiting for mul_done; result written to hi/lo on arrival
// ST_DRAIN | flushed; waiting for mul_done, result discarded
module hilo_unit
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  hilo_op_t    req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        busy,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  mul_op,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_c,
    input  logic        mul_done
);

    hilo_state_t state, state_nxt;
    logic        accept;
    logic        mul_start;
    logic        res_wr;
    logic [63:0] hilo_res;

    // A flush in IDLE blocks acceptance, so ready is withdrawn with it.
    assign req_ready = (state == ST_IDLE) && !flush;
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign res_wr    = (state == ST_WAIT) && mul_done && !flush;

`ifdef HILO_MADD_EN
    hilo_op_t op_q;

    assign mul_start = accept && (req_op == OP_MULT || req_op == OP_MULTU || is_acc(req_op));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q <= OP_NOP;
        end else if (mul_start) begin
            op_q <= req_op;
        end
    end

    always_comb begin
        hilo_res = mul_c;
        case (op_q)
            OP_MADDU, OP_MADD: hilo_res = {hi, lo} + mul_c;
            OP_MSUB:           hilo_res = {hi, lo} - mul_c;
            default:           hilo_res = mul_c;
        endcase
    end
`else
    assign mul_start = accept && (req_op == OP_MULT || req_op == OP_MULTU);
    assign hilo_res  = mul_c;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (mul_start) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (mul_done)   state_nxt = ST_IDLE;
                else if (flush) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (mul_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // mul_op is only non-idle in the cycle after acceptance, i.e. while in ISSUE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi     <= '0;
            lo     <= '0;
            mul_op <= MUL_IDLE;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            mul_op <= mul_start ? mul_encoding(req_op) : MUL_IDLE;
            if (mul_start) begin
                mul_a <= req_a;
                mul_b <= req_b;
            end
            if (res_wr) begin
                {hi, lo} <= hilo_res;
            end else if (accept && req_op == OP_MTHI) begin
                hi <= req_a;
            end else if (accept && req_op == OP_MTLO) begin
                lo <= req_a;
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed cases plus randomized traffic
// against a transaction-level model, with a bench-side multiplier.
module tb_hilo_unit;
    import hilo_pkg::*;

`ifdef HILO_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    hilo_op_t    req_op = OP_NOP;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_ready;
    logic        busy;
    logic        flush = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  mul_op;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_c;
    logic        mul_done;

    int checks = 0;
    int errors = 0;
    int fixed_lat = 4;

    hilo_unit dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .busy(busy),
        .flush(flush), .hi(hi), .lo(lo), .mul_op(mul_op), .mul_a(mul_a),
        .mul_b(mul_b), .mul_c(mul_c), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit op_signed(input hilo_op_t op);
        return (op == OP_MULT || op == OP_MADD || op == OP_MSUB);
    endfunction

    function automatic bit starts_mul(input hilo_op_t op);
        if (op == OP_MULT || op == OP_MULTU) return 1'b1;
        return MADD_EN && (op == OP_MADDU || op == OP_MADD || op == OP_MSUB);
    endfunction

    function automatic logic [63:0] product(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    // Reference model: one in-flight transaction, HI/LO as a 64-bit value.
    logic [63:0] m_hilo;
    bit          m_busy, m_issue, m_discard;
    hilo_op_t    m_op;
    logic [31:0] m_a, m_b;
    // Bench-side multiplier
    logic [63:0] mul_prod;
    int          mul_left;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hilo = '0; m_busy = 0; m_issue = 0; m_discard = 0;
            m_op = OP_NOP; m_a = '0; m_b = '0;
            mul_done <= 1'b1; mul_c <= '0; mul_prod <= '0; mul_left <= 0;
        end else begin
            if (!m_busy) begin
                if (req_valid && !flush) begin
                    if (req_op == OP_MTHI) m_hilo[63:32] = req_a;
                    else if (req_op == OP_MTLO) m_hilo[31:0] = req_a;
                    else if (starts_mul(req_op)) begin
                        m_busy = 1; m_issue = 1; m_discard = 0;
                        m_op = req_op; m_a = req_a; m_b = req_b;
                    end
                end
            end else if (m_issue) begin
                m_issue = 0;
                if (flush) m_discard = 1;
            end else if (mul_done) begin
                if (!m_discard && !flush) begin
                    if (m_op == OP_MADDU || m_op == OP_MADD)
                        m_hilo = m_hilo + product(op_signed(m_op), m_a, m_b);
                    else if (m_op == OP_MSUB)
                        m_hilo = m_hilo - product(op_signed(m_op), m_a, m_b);
                    else
                        m_hilo = product(op_signed(m_op), m_a, m_b);
                end
                m_busy = 0;
            end else if (flush) begin
                m_discard = 1;
            end

            if (mul_op != 2'b00) begin
                mul_done <= 1'b0;
                mul_left <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
                mul_prod <= product(mul_op == 2'b10, mul_a, mul_b);
                mul_c    <= {$urandom, $urandom};
            end else if (!mul_done) begin
                if (mul_left <= 1) begin
                    mul_done <= 1'b1;
                    mul_c    <= mul_prod;
                end else begin
                    mul_left <= mul_left - 1;
                    mul_c    <= {$urandom, $urandom};
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (resetn) begin
            chk("cyc_hi", hi, m_hilo[63:32]);
            chk("cyc_lo", lo, m_hilo[31:0]);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_ready", req_ready, !m_busy && !flush);
            chk("cyc_mul_op", mul_op, m_issue ? (op_signed(m_op) ? 2'b10 : 2'b01) : 2'b00);
            if (m_issue) begin
                chk("cyc_mul_a", mul_a, m_a);
                chk("cyc_mul_b", mul_b, m_b);
            end
        end
    end

    // Called just after a negedge; presents the request for one cycle.
    task automatic send(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; flush = fl;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_op", mul_op, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_ready", req_ready, 1);
        resetn = 1'b1;
        @(negedge clk);

        // MULT -2*3 with a 4-cycle multiplier: exact latency pinned
        fixed_lat = 4;
        send(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_issue_op", mul_op, 2'b10);
        chk("mult_issue_busy", busy, 1);
        @(negedge clk);
        chk("mult_issue_once", mul_op, 2'b00);
        repeat (4) @(negedge clk);
        chk("mult_edge5_busy", busy, 1);
        @(negedge clk);
        chk("mult_edge6_ready", req_ready, 1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("model_pin_mult", m_hilo, 64'hFFFF_FFFF_FFFF_FFFA);

        // Back-to-back MTHI/MTLO without a busy cycle
        req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h1234_5678;
        chk("mthi_ready", req_ready, 1);
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", busy, 0);
        chk("mthi_ready_after", req_ready, 1);
        req_op = OP_MTLO; req_a = 32'h9ABC_DEF0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);
        chk("mtlo_busy", busy, 0);

        // Signed corner: (-2^31)^2 = 2^62
        send(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_idle();
        chk("mult_min_hi", hi, 32'h4000_0000);
        chk("mult_min_lo", lo, 32'h0000_0000);

`ifdef HILO_MADD_EN
        send(OP_MTHI, 32'h0, 32'h0, 1'b0);
        send(OP_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
        send(OP_MADDU, 32'd1, 32'd1, 1'b0);
        wait_idle();
        chk("maddu_hi", hi, 32'h1);
        chk("maddu_lo", lo, 32'h0);
        send(OP_MSUB, 32'd1, 32'd1, 1'b0);
        wait_idle();
        chk("msub_hi", hi, 32'h0);
        chk("msub_lo", lo, 32'hFFFF_FFFF);
`else
        send(OP_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0);
        send(OP_MTLO, 32'h5A5A_5A5A, 32'h0, 1'b0);
        send(OP_MADD, 32'd5, 32'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("madd_off_mul_op", mul_op, 2'b00);
            chk("madd_off_busy", busy, 0);
            @(negedge clk);
        end
        chk("madd_off_hi", hi, 32'hA5A5_A5A5);
        chk("madd_off_lo", lo, 32'h5A5A_5A5A);
`endif

        // Flush while waiting: result discarded, next request accepted
        send(OP_MTHI, 32'hCAFE_0001, 32'h0, 1'b0);
        send(OP_MTLO, 32'hCAFE_0002, 32'h0, 1'b0);
        send(OP_MULTU, 32'd7, 32'd6, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_busy", busy, 1);
        wait_idle();
        chk("drain_hi", hi, 32'hCAFE_0001);
        chk("drain_lo", lo, 32'hCAFE_0002);
        send(OP_MULTU, 32'd7, 32'd6, 1'b0);
        wait_idle();
        chk("after_drain_hi", hi, 32'h0);
        chk("after_drain_lo", lo, 32'd42);

        // Flush in IDLE blocks the concurrent request
        req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'hDEAD_BEEF; flush = 1'b1;
        #1;
        chk("flush_idle_ready", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_hi", hi, 32'h0);

        // Randomized traffic with random multiplier latency
        fixed_lat = 0;
        for (int i = 0; i < 800; i++) begin
            req_valid = ($urandom_range(0, 99) < 60);
            rop = 3'($urandom_range(0, 7));
            req_op = hilo_op_t'(rop);
            req_a = pick();
            req_b = pick();
            flush = ($urandom_range(0, 99) < 8);
            @(negedge clk);
        end
        req_valid = 1'b0; flush = 1'b0;
        wait_idle();

        // Asynchronous reset in WAIT
        fixed_lat = 4;
        send(OP_MTHI, 32'h0000_1234, 32'h0, 1'b0);
        send(OP_MULT, 32'd3, 32'd5, 1'b0);
        repeat (2) @(negedge clk);
        chk("prereset_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", req_ready, 1);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_mul_op", mul_op, 0);
        chk("arst_mul_a", mul_a, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
